// File: rtl/isa_pkg.sv
// isa_pkg: shared opcodes, instruction field positions and class flags for Fetch/Decode/Execute
package isa_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RW = $clog2(NREG);
  localparam int PCW = 5;
  localparam int OPC_W = 7;
  localparam int OPC_LO = 25;
  localparam int DST_LO = 20;
  localparam int SRC1_LO = 15;
  localparam int SRC2_LO = 10;
  localparam int OFF_LO = 0;
  localparam int OFF_W = 15;
  localparam int BLO_W = 10;
  localparam logic [OPC_W-1:0] OP_ADD = 7'h00;
  localparam logic [OPC_W-1:0] OP_SUB = 7'h01;
  localparam logic [OPC_W-1:0] OP_MUL = 7'h02;
  localparam logic [OPC_W-1:0] OP_LDB = 7'h10;
  localparam logic [OPC_W-1:0] OP_LDW = 7'h11;
  localparam logic [OPC_W-1:0] OP_STB = 7'h12;
  localparam logic [OPC_W-1:0] OP_STW = 7'h13;
  localparam logic [OPC_W-1:0] OP_BEQ = 7'h30;
  localparam logic [OPC_W-1:0] OP_JUMP = 7'h31;
  typedef struct packed {
    logic wr_en;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic illegal;
  } cls_t;
  function automatic cls_t classify(input logic [OPC_W-1:0] op);
    cls_t c;
    logic is_r;
    is_r = op inside {OP_ADD, OP_SUB, OP_MUL};
    c.is_load = op inside {OP_LDB, OP_LDW};
    c.is_store = op inside {OP_STB, OP_STW};
    c.is_branch = op inside {OP_BEQ, OP_JUMP};
    c.wr_en = is_r | c.is_load;
    c.illegal = ~(is_r | c.is_load | c.is_store | c.is_branch);
    return c;
  endfunction
  function automatic logic [XLEN-1:0] sext(input logic [OFF_W-1:0] v);
    return {{(XLEN-OFF_W){v[OFF_W-1]}}, v};
  endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32x32 register file, r0 hardwired zero, write-through bypass, three read ports
module regfile_2r1w import isa_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [RW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [RW-1:0]   ra,
  input  logic [RW-1:0]   rb,
  input  logic [RW-1:0]   rc,
  output logic [XLEN-1:0] da,
  output logic [XLEN-1:0] db,
  output logic [XLEN-1:0] dc
);
  logic [XLEN-1:0] mem [NREG];
  function automatic logic [XLEN-1:0] rd(input logic [RW-1:0] a);
    return (a == '0) ? '0 : (we && wa == a) ? wd : mem[a];
  endfunction
  // storage; r0 is never written so it stays at its reset value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we && wa != '0)
      mem[wa] <= wd;
  assign da = rd(ra);
  assign db = rd(rb);
  assign dc = rd(rc);
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes the Fetch instruction, reads operands, detects load-use hazards, registers the bundle
module decode_stage import isa_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  ins_in,
  input  logic [PCW-1:0]   pc_in,
  input  logic             ins_valid,
  input  logic             ex_stall,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [RW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             fetch_stall,
  output logic             out_valid,
  output logic [OPC_W-1:0] out_opcode,
  output logic [RW-1:0]    out_dst,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [XLEN-1:0]  out_imm,
  output logic [PCW-1:0]   out_pc,
  output logic             out_wr_en,
  output logic             out_is_load,
  output logic             out_is_store,
  output logic             out_is_branch,
  output logic             out_illegal
);
  logic [OPC_W-1:0] opc;
  logic [RW-1:0] dst, s1, s2;
  logic [XLEN-1:0] rd_a, rd_b, rd_c, imm, opb;
  cls_t cls;
  logic is_r, use2, haz;
  regfile_2r1w u_rf (
    .clk(clk), .rst_n(rst_n), .we(wb_en), .wa(wb_addr), .wd(wb_data),
    .ra(s1), .rb(s2), .rc(dst), .da(rd_a), .db(rd_b), .dc(rd_c)
  );
  // field extraction, immediate formation and load-use hazard against the bundle in Execute's input
  always_comb begin
    opc = ins_in[OPC_LO +: OPC_W];
    dst = ins_in[DST_LO +: RW];
    s1 = ins_in[SRC1_LO +: RW];
    s2 = ins_in[SRC2_LO +: RW];
    cls = classify(opc);
    is_r = cls.wr_en & ~cls.is_load;
    use2 = is_r | (opc == OP_BEQ);
    imm = (cls.is_load | cls.is_store) ? sext(ins_in[OFF_LO +: OFF_W]) :
          cls.is_branch ? sext({dst, ins_in[0 +: BLO_W]}) :
          is_r ? XLEN'(ins_in[0 +: BLO_W]) : '0;
    opb = cls.is_store ? rd_c : rd_b;
    haz = ins_valid & out_valid & out_is_load & (out_dst != '0) &
          ((out_dst == s1) | (use2 & (out_dst == s2)) | (cls.is_store & (out_dst == dst)));
  end
  assign fetch_stall = haz | ex_stall;
  // bundle register: flush and hazard insert a bubble, ex_stall freezes everything
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_opcode <= '0;
      out_dst <= '0;
      out_a <= '0;
      out_b <= '0;
      out_imm <= '0;
      out_pc <= '0;
      {out_wr_en, out_is_load, out_is_store, out_is_branch, out_illegal} <= '0;
    end else if (flush || (!ex_stall && haz))
      out_valid <= 1'b0;
    else if (!ex_stall) begin
      out_valid <= ins_valid;
      out_opcode <= opc;
      out_dst <= dst;
      out_a <= rd_a;
      out_b <= opb;
      out_imm <= imm;
      out_pc <= pc_in;
      {out_wr_en, out_is_load, out_is_store, out_is_branch, out_illegal} <= cls;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven vectors and corner sequences checked through a scoreboard queue
module tb_decode_stage;
  import isa_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] ins_in = '0;
  logic [4:0] pc_in = '0;
  logic ins_valid = 1'b0, ex_stall = 1'b0, flush = 1'b0, wb_en = 1'b0;
  logic [4:0] wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic fetch_stall, out_valid, out_wr_en, out_is_load, out_is_store, out_is_branch, out_illegal;
  logic [6:0] out_opcode;
  logic [4:0] out_dst, out_pc;
  logic [31:0] out_a, out_b, out_imm;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .ins_in(ins_in), .pc_in(pc_in), .ins_valid(ins_valid),
    .ex_stall(ex_stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .fetch_stall(fetch_stall), .out_valid(out_valid), .out_opcode(out_opcode), .out_dst(out_dst),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_pc(out_pc), .out_wr_en(out_wr_en),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_branch(out_is_branch),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v;
    logic [6:0] op;
    logic [4:0] dst;
    logic [31:0] a, b, imm;
    logic [4:0] pc;
    logic [4:0] fl;
  } exp_t;
  typedef struct {
    logic [31:0] ins;
    logic [4:0] pc;
    logic v, we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic stall;
    exp_t e;
  } vec_t;

  localparam logic [4:0] FR = 5'b10000, FL = 5'b11000, FS = 5'b00100, FB = 5'b00010, FI = 5'b00001;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  exp_t sb[$];
  vec_t tv[$];
  int nvec = 0, nbad = 0;

  function automatic logic [31:0] ri(logic [6:0] op, logic [4:0] d, logic [4:0] a, logic [4:0] b, logic [9:0] lo);
    return {op, d, a, b, lo};
  endfunction
  function automatic logic [31:0] mi(logic [6:0] op, logic [4:0] d, logic [4:0] a, logic [14:0] off);
    return {op, d, a, off};
  endfunction
  function automatic exp_t ex(logic v, logic [6:0] op, logic [4:0] d, logic [31:0] a, logic [31:0] b,
                              logic [31:0] imm, logic [4:0] p, logic [4:0] fl);
    return '{v, op, d, a, b, imm, p, fl};
  endfunction

  task automatic add(logic [31:0] i, logic [4:0] p, logic v, logic we, logic [4:0] wa, logic [31:0] wd,
                     logic st, exp_t e);
    vec_t t;
    t.ins = i; t.pc = p; t.v = v; t.we = we; t.wa = wa; t.wd = wd; t.stall = st; t.e = e;
    tv.push_back(t);
  endtask

  task automatic chk(string n, logic [31:0] got, logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %h, want %h", n, got, want);
    end
  endtask

  task automatic compare(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      nbad++;
      $display("FAIL %s: scoreboard empty, got valid %b, want an expected entry", tag, out_valid);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".valid"}, 32'(out_valid), 32'(e.v));
    if (e.v) begin
      chk({tag, ".opcode"}, 32'(out_opcode), 32'(e.op));
      chk({tag, ".dst"}, 32'(out_dst), 32'(e.dst));
      chk({tag, ".a"}, out_a, e.a);
      chk({tag, ".b"}, out_b, e.b);
      chk({tag, ".imm"}, out_imm, e.imm);
      chk({tag, ".pc"}, 32'(out_pc), 32'(e.pc));
      chk({tag, ".flags"}, 32'({out_wr_en, out_is_load, out_is_store, out_is_branch, out_illegal}), 32'(e.fl));
    end
  endtask

  task automatic step(string tag, logic st, exp_t e);
    #1 chk({tag, ".stall"}, 32'(fetch_stall), 32'(st));
    sb.push_back(e);
    @(posedge clk);
    #1 compare(tag);
  endtask

  task automatic drv(logic [31:0] i, logic [4:0] p, logic v);
    ins_in = i; pc_in = p; ins_valid = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t bub;
    bub = ex(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 7, 0, bub);
    add(0, 0, 0, 1, 3, DB, 0, bub);
    add(ri(OP_ADD, 5, 1, 3, 10'h3FF), 1, 1, 0, 0, 0, 0, ex(1, OP_ADD, 5, 7, DB, 32'h3FF, 1, FR));
    add(ri(OP_SUB, 6, 3, 2, 0), 2, 1, 1, 2, 32'h55, 0, ex(1, OP_SUB, 6, DB, 32'h55, 0, 2, FR));
    add(ri(OP_MUL, 7, 0, 0, 0), 3, 1, 1, 0, 32'h1234, 0, ex(1, OP_MUL, 7, 0, 0, 0, 3, FR));
    add(ri(OP_MUL, 8, 2, 0, 1), 4, 1, 0, 0, 0, 0, ex(1, OP_MUL, 8, 32'h55, 0, 1, 4, FR));
    add(ri(OP_BEQ, 5'b10000, 1, 3, 0), 5, 1, 0, 0, 0, 0, ex(1, OP_BEQ, 16, 7, DB, 32'hFFFFC000, 5, FB));
    add(mi(OP_LDW, 9, 1, 15'h7FFF), 6, 1, 0, 0, 0, 0, ex(1, OP_LDW, 9, 7, 0, 32'hFFFFFFFF, 6, FL));
    add(mi(OP_STW, 3, 2, 15'h0010), 7, 1, 0, 0, 0, 0, ex(1, OP_STW, 3, 32'h55, DB, 32'h10, 7, FS));
    add(32'hFE000000, 8, 1, 0, 0, 0, 0, ex(1, 7'h7F, 0, 0, 0, 0, 8, FI));
    add(ri(OP_JUMP, 1, 0, 0, 3), 9, 1, 0, 0, 0, 0, ex(1, OP_JUMP, 1, 0, 0, 32'h403, 9, FB));
    add(mi(OP_LDB, 0, 1, 0), 10, 1, 0, 0, 0, 0, ex(1, OP_LDB, 0, 7, 0, 0, 10, FL));
    add(ri(OP_ADD, 1, 0, 0, 0), 11, 1, 0, 0, 0, 0, ex(1, OP_ADD, 1, 0, 0, 0, 11, FR));
    add(mi(OP_LDW, 4, 1, 0), 12, 1, 0, 0, 0, 0, ex(1, OP_LDW, 4, 7, 0, 0, 12, FL));
    add(ri(OP_ADD, 6, 4, 1, 0), 13, 1, 0, 0, 0, 1, bub);
    add(ri(OP_ADD, 6, 4, 1, 0), 13, 1, 0, 0, 0, 0, ex(1, OP_ADD, 6, 0, 7, 0, 13, FR));
    add(mi(OP_LDW, 10, 1, 0), 14, 1, 0, 0, 0, 0, ex(1, OP_LDW, 10, 7, 0, 0, 14, FL));
    add(mi(OP_STW, 10, 2, 0), 15, 1, 0, 0, 0, 1, bub);
    add(mi(OP_STW, 10, 2, 0), 15, 1, 0, 0, 0, 0, ex(1, OP_STW, 10, 32'h55, 0, 0, 15, FS));
    add(mi(OP_LDW, 11, 1, 0), 16, 1, 0, 0, 0, 0, ex(1, OP_LDW, 11, 7, 0, 0, 16, FL));
    add(ri(OP_JUMP, 11, 0, 11, 0), 17, 1, 0, 0, 0, 0, ex(1, OP_JUMP, 11, 0, 0, 32'h2C00, 17, FB));
    add(mi(OP_LDW, 12, 1, 0), 18, 1, 0, 0, 0, 0, ex(1, OP_LDW, 12, 7, 0, 0, 18, FL));
    add(ri(OP_BEQ, 0, 0, 12, 0), 19, 1, 0, 0, 0, 1, bub);
    add(ri(OP_BEQ, 0, 0, 12, 0), 19, 1, 0, 0, 0, 0, ex(1, OP_BEQ, 0, 0, 0, 0, 19, FB));
    add(mi(OP_LDW, 13, 1, 0), 20, 1, 0, 0, 0, 0, ex(1, OP_LDW, 13, 7, 0, 0, 20, FL));
    add(ri(OP_ADD, 1, 13, 0, 0), 21, 0, 0, 0, 0, 0, bub);

    #12;
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.flags", 32'({out_wr_en, out_is_load, out_is_store, out_is_branch, out_illegal}), 0);
    chk("rst.a", out_a, 0);
    chk("rst.b", out_b, 0);
    chk("rst.imm", out_imm, 0);
    chk("rst.fields", {15'b0, out_opcode, out_dst, out_pc}, 0);
    chk("rst.stall", 32'(fetch_stall), 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      drv(tv[i].ins, tv[i].pc, tv[i].v);
      wb_en = tv[i].we; wb_addr = tv[i].wa; wb_data = tv[i].wd;
      step($sformatf("v%0d", i), tv[i].stall, tv[i].e);
    end

    @(negedge clk);
    wb_en = 1'b0;
    drv(ri(OP_ADD, 2, 1, 3, 5), 21, 1);
    step("stl.pre", 0, ex(1, OP_ADD, 2, 7, DB, 5, 21, FR));
    @(negedge clk);
    ex_stall = 1'b1;
    drv(ri(OP_SUB, 3, 2, 2, 0), 22, 1);
    wb_en = 1'b1; wb_addr = 1; wb_data = 32'h99;
    for (int k = 0; k < 3; k++) begin
      step($sformatf("stl.hold%0d", k), 1, ex(1, OP_ADD, 2, 7, DB, 5, 21, FR));
      @(negedge clk);
    end
    wb_en = 1'b0;
    flush = 1'b1;
    step("stl.flush", 1, bub);
    @(negedge clk);
    flush = 1'b0; ex_stall = 1'b0;
    drv(ri(OP_SUB, 3, 1, 2, 0), 22, 1);
    step("stl.post", 0, ex(1, OP_SUB, 3, 32'h99, 32'h55, 0, 22, FR));

    @(negedge clk);
    drv(mi(OP_LDW, 4, 1, 0), 23, 1);
    step("fh.ld", 0, ex(1, OP_LDW, 4, 32'h99, 0, 0, 23, FL));
    @(negedge clk);
    drv(ri(OP_ADD, 6, 4, 1, 0), 24, 1);
    flush = 1'b1;
    step("fh.both", 1, bub);
    @(negedge clk);
    flush = 1'b0;
    step("fh.issue", 0, ex(1, OP_ADD, 6, 0, 32'h99, 0, 24, FR));
    @(negedge clk);
    drv(ri(OP_SUB, 3, 1, 2, 0), 25, 1);
    flush = 1'b1;
    step("fl.only", 0, bub);
    @(negedge clk);
    flush = 1'b0;
    drv(ri(OP_ADD, 5, 1, 3, 0), 26, 1);
    step("ar.pre", 0, ex(1, OP_ADD, 5, 32'h99, DB, 0, 26, FR));

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(out_valid), 0);
    chk("ar.flags", 32'({out_wr_en, out_is_load, out_is_store, out_is_branch, out_illegal}), 0);
    chk("ar.a", out_a, 0);
    chk("ar.b", out_b, 0);
    chk("ar.fields", {15'b0, out_opcode, out_dst, out_pc}, 0);
    @(negedge clk) rst_n = 1'b1;
    drv(ri(OP_ADD, 5, 1, 3, 0), 27, 1);
    step("ar.post", 0, ex(1, OP_ADD, 5, 0, 0, 0, 27, FR));

    if (sb.size() != 0) begin
      nbad++;
      $display("FAIL sb.drain: got %0d leftover entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage, directly downstream of Fetch; consumes the registered 32-bit instruction word and its PC.
- Owns the 32x32 architectural register file, with write-back port and same-cycle bypass.
- Decodes R/M/B formats, sign-extends offsets, detects load-use hazards and stalls Fetch.
- Registers the decoded bundle for the Execute stage.

Parameters:
- XLEN, 32, data/instruction width.
- NREG, 32, register count; index width 5.
- PCW, 5, PC width (matches Fetch jumpPC/PC).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ins_in  in  32  instruction from Fetch insReg
- pc_in  in  5  PC of ins_in
- ins_valid  in  1  ins_in holds a real instruction
- ex_stall  in  1  Execute cannot accept; hold outputs
- flush  in  1  branch/jump taken; kill the instruction being decoded
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write index
- wb_data  in  32  write data
- fetch_stall  out  1  combinational; Fetch must hold PC and insReg
- out_valid  out  1  decoded bundle valid
- out_opcode  out  7  ins[31:25]
- out_dst  out  5  ins[24:20]
- out_a  out  32  rf[src1 = ins[19:15]]
- out_b  out  32  R/B: rf[ins[14:10]]; store: rf[ins[24:20]]
- out_imm  out  32  sign-extended offset
- out_pc  out  5  PC of the bundle
- out_wr_en, out_is_load, out_is_store, out_is_branch, out_illegal  out  1 each  class flags

Behaviour:
- Reset (async, rst_n=0): all outputs 0; all 32 registers 0. Release is synchronous to clk.
- Opcodes:
  - R-type: 00 ADD, 01 SUB, 02 MUL.
  - M-type: 10 LDB, 11 LDW, 12 STB, 13 STW.
  - B-type: 30 BEQ, 31 JUMP.
  - Any other opcode: out_illegal=1, all other flags 0, out_wr_en=0.
- Immediates:
  - M-type: out_imm = sext(ins[14:0]).
  - B-type: out_imm = sext({ins[24:20], ins[9:0]}).
  - R-type: out_imm = zext(ins[9:0]).
- out_wr_en = 1 for R-type and loads only.
- Register file:
  - Write on posedge when wb_en=1 and wb_addr!=0.
  - r0 always reads 0.
  - Bypass: if wb_en=1, wb_addr equals the read index, and the index is not 0, the read returns wb_data in the same cycle.
- Hazard, combinational:
  - haz = ins_valid & out_valid & out_is_load & (out_dst != 0) & (out_dst matches a used source of ins_in).
  - Used sources: src1 always; src2 for R-type and BEQ; ins[24:20] for stores.
- fetch_stall = haz | ex_stall.
- Per-cycle update, priority order:
  1. flush: out_valid <= 0; other outputs don't-care but hold.
  2. ex_stall: all outputs hold.
  3. haz: out_valid <= 0 (bubble); Fetch re-presents the same ins_in next cycle.
  4. Otherwise: bundle <= decode(ins_in); out_valid <= ins_valid.
- Latency: 1 cycle from ins_in to outputs. One bubble per load-use hazard.
- flush together with ex_stall: flush wins.
- flush together with haz: bubble; fetch_stall is still driven by haz.
- A register write during a held ex_stall does not update the held out_a/out_b. Execute forwards these values.

Decomposition:
- Shared package isa_pkg:
  - opcode localparams.
  - field bit positions (OPC, DST, SRC1, SRC2, OFF).
  - a class-flag struct or encoding used by Fetch/Decode/Execute.
- One sub-module, regfile_2r1w: 32x32 array with async reset, r0 zero, write-through bypass, two read ports plus one extra read for the store-data field. A mux selects the extra read into port B.

Test Plan:
- Reset, then pulse wb_en: addr 3, data 0xDEADBEEF. Then ADD r3,r1->r5 with r1=7 → next cycle out_a=7, out_b=0xDEADBEEF, out_wr_en=1, out_valid=1.
- wb_en addr 2, data 0x55 in the same cycle as decoding ADD src2=r2 → out_b=0x55 (bypass). Write to r0 → r0 still reads 0.
- LDW r4 followed by ADD r6,r4,r1 → fetch_stall=1 for exactly one cycle. The next cycle carries a bubble (out_valid=0), then the ADD issues.
- BEQ with ins[24:20]=5'b10000, ins[9:0]=0 → out_imm=0xFFFFC000, out_is_branch=1. M-type with offset 15'h7FFF → out_imm=0xFFFFFFFF.
- ex_stall held for 3 cycles with new ins_in applied → outputs frozen and fetch_stall=1. flush with ex_stall → out_valid=0 next cycle.
- Opcode 7'h7F → out_illegal=1, out_wr_en=0. rst_n low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
